// File: rtl/sha_msg_padder.sv
// SHA-256 message padder: packs 32-bit words into 512-bit blocks, appends 0x80,
// zero fill and the 64-bit big-endian bit length, emitting an extra block when needed.
module sha_msg_padder (
   input  logic         clk_p,
   input  logic         rst_p,
   input  logic [31:0]  in_data,
   input  logic         in_valid,
   input  logic         in_last,
   input  logic [2:0]   in_nbytes,
   output logic         in_ready,
   output logic [511:0] msg_data,
   output logic         msg_valid,
   input  logic         msg_rdy,
   output logic         msg_first,
   output logic         msg_last
);
   localparam int unsigned WORD_W         = 32;
   localparam int unsigned NWORDS         = 16;
   localparam int unsigned IDX_W          = 4;
   localparam int unsigned CNT_W          = 64;
   localparam int unsigned OCC_W          = 7;
   localparam int unsigned LEN_SLOT_BYTES = 56;

   typedef enum logic {FILL, SEND} state_t;

   state_t                        state_q, state_d;
   logic [NWORDS-1:0][WORD_W-1:0] blk_q, blk_d;
   logic [IDX_W-1:0]              idx_q, idx_d, idx_nxt;
   logic [CNT_W-1:0]              cnt_q, cnt_d, len_q, len_d;
   logic [CNT_W-1:0]              bytes_tot, bit_len;
   logic                          first_d, last_d;
   logic                          fpend_q, fpend_d;
   logic                          pend_q, pend_d, pend80_q, pend80_d;
   logic [2:0]                    nb;
   logic [OCC_W-1:0]              occ;
   logic [WORD_W-1:0]             keep_mask, pad_word;
   logic                          accept, hs;

   assign msg_data = blk_q;
   assign accept   = in_valid & in_ready;
   assign hs       = msg_valid & msg_rdy;
   assign idx_nxt  = idx_q + IDX_W'(1);
   assign nb       = (in_nbytes > 3'd4) ? 3'd4 : in_nbytes;
   // Bytes occupied by data plus the 0x80 marker; same form whether 0x80 lands in this word or the next.
   assign occ       = OCC_W'({idx_q, 2'b00}) + OCC_W'(nb) + OCC_W'(1);
   assign bytes_tot = cnt_q + CNT_W'(nb);
   assign bit_len   = {bytes_tot[CNT_W-4:0], 3'b000};

   // Left-justified byte keep mask and 0x80 marker for the final word
   always_comb begin
      keep_mask = '1;
      pad_word  = '0;
      unique case (nb)
         3'd0: begin keep_mask = 32'h0000_0000; pad_word = 32'h8000_0000; end
         3'd1: begin keep_mask = 32'hFF00_0000; pad_word = 32'h0080_0000; end
         3'd2: begin keep_mask = 32'hFFFF_0000; pad_word = 32'h0000_8000; end
         3'd3: begin keep_mask = 32'hFFFF_FF00; pad_word = 32'h0000_0080; end
         default: begin keep_mask = 32'hFFFF_FFFF; pad_word = 32'h0000_0000; end
      endcase
   end

   always_comb begin
      state_d  = state_q;
      blk_d    = blk_q;
      idx_d    = idx_q;
      cnt_d    = cnt_q;
      len_d    = len_q;
      first_d  = msg_first;
      last_d   = msg_last;
      fpend_d  = fpend_q;
      pend_d   = pend_q;
      pend80_d = pend80_q;
      unique case (state_q)
         FILL: begin
            if (accept) begin
               if (!in_last) begin
                  blk_d[~idx_q] = in_data;
                  cnt_d         = cnt_q + CNT_W'(4);
                  if (idx_q == IDX_W'(NWORDS - 1)) begin
                     state_d = SEND;
                     first_d = fpend_q;
                     fpend_d = 1'b0;
                     last_d  = 1'b0;
                  end else begin
                     idx_d = idx_nxt;
                  end
               end else begin
                  blk_d[~idx_q] = (in_data & keep_mask) | pad_word;
                  cnt_d         = bytes_tot;
                  len_d         = bit_len;
                  state_d       = SEND;
                  first_d       = fpend_q;
                  fpend_d       = 1'b0;
                  if (nb == 3'd4 && idx_q != IDX_W'(NWORDS - 1))
                     blk_d[~idx_nxt] = 32'h8000_0000;
                  if (occ <= OCC_W'(LEN_SLOT_BYTES)) begin
                     blk_d[1] = bit_len[CNT_W-1:WORD_W];
                     blk_d[0] = bit_len[WORD_W-1:0];
                     last_d   = 1'b1;
                  end else begin
                     last_d   = 1'b0;
                     pend_d   = 1'b1;
                     pend80_d = (nb == 3'd4) && (idx_q == IDX_W'(NWORDS - 1));
                  end
               end
            end
         end
         SEND: begin
            if (hs) begin
               if (pend_q) begin
                  // Trailing length-only block, loaded in place so msg_valid never drops
                  blk_d             = '0;
                  blk_d[NWORDS-1]   = pend80_q ? 32'h8000_0000 : 32'h0000_0000;
                  blk_d[1]          = len_q[CNT_W-1:WORD_W];
                  blk_d[0]          = len_q[WORD_W-1:0];
                  first_d           = 1'b0;
                  last_d            = 1'b1;
                  pend_d            = 1'b0;
                  pend80_d          = 1'b0;
               end else begin
                  state_d = FILL;
                  blk_d   = '0;
                  idx_d   = '0;
                  first_d = 1'b0;
                  last_d  = 1'b0;
                  if (msg_last) begin
                     cnt_d   = '0;
                     fpend_d = 1'b1;
                  end
               end
            end
         end
         default: state_d = FILL;
      endcase
   end

   always_ff @(posedge clk_p or posedge rst_p) begin
      if (rst_p) state_q <= FILL;
      else       state_q <= state_d;
   end

   always_ff @(posedge clk_p or posedge rst_p) begin
      if (rst_p) begin
         blk_q     <= '0;
         idx_q     <= '0;
         cnt_q     <= '0;
         len_q     <= '0;
         fpend_q   <= 1'b1;
         pend_q    <= 1'b0;
         pend80_q  <= 1'b0;
         in_ready  <= 1'b0;
         msg_valid <= 1'b0;
         msg_first <= 1'b0;
         msg_last  <= 1'b0;
      end else begin
         blk_q     <= blk_d;
         idx_q     <= idx_d;
         cnt_q     <= cnt_d;
         len_q     <= len_d;
         fpend_q   <= fpend_d;
         pend_q    <= pend_d;
         pend80_q  <= pend80_d;
         in_ready  <= (state_d == FILL);
         msg_valid <= (state_d == SEND);
         msg_first <= first_d;
         msg_last  <= last_d;
      end
   end
endmodule
